z80_shadow_ctrl: RTL

Z80_SHADOW_CTRL -- requirements
Module: z80_shadow_ctrl

---
 rtl/z80_shadow_pkg.sv | 16 +
 rtl/z80_sync2.sv | 25 ++
 rtl/z80_shadow_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/z80_shadow_pkg.sv
// Shared types and default I/O port numbers for the Z80 shadow-ROM controller.
package z80_shadow_pkg;

   // Port-decode FSM: wait for a strobe, act on the latched port, wait for IORQ release.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      HOLD   = 2'd2
   } state_e;

   localparam int unsigned PAGE_W_DEF    = 2;
   localparam logic [7:0]  PORT_ON_DEF   = 8'hFB;
   localparam logic [7:0]  PORT_OFF_DEF  = 8'h7B;
   localparam logic [7:0]  PORT_PAGE_DEF = 8'hFD;

endpackage

// File: rtl/z80_sync2.sv
// Two-flop synchroniser for an active-low Z80 strobe; resets to the inactive (1) level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronised output
module z80_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/z80_shadow_ctrl.sv
// Shadow-RAM window controller for a Z80: I/O port reads switch the window on/off,
// an I/O write loads the SRAM bank and write-protect bit, and SRAM strobes are
// derived live from the CPU bus.
//   clk, reset        : clock, asynchronous active-low reset
//   bsrq              : BUSRQ, low = bus owned by another master
//   mreq/iorq/rd/wr   : active-low Z80 strobes
//   A, A14, A15, D    : CPU address and data
//   lsoe              : level-shifter output enable (~bsrq)
//   moe, mwe, mce     : SRAM OE/WE/CE, active-low
//   ma                : SRAM bank bits (registered)
//   romblk            : onboard ROM block, high while window enabled (registered)
//   wp                : write-protect status (registered)
module z80_shadow_ctrl
   import z80_shadow_pkg::*;
#(
   parameter int unsigned PAGE_W    = PAGE_W_DEF,
   parameter logic [7:0]  PORT_ON   = PORT_ON_DEF,
   parameter logic [7:0]  PORT_OFF  = PORT_OFF_DEF,
   parameter logic [7:0]  PORT_PAGE = PORT_PAGE_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bsrq,
   input  logic              mreq,
   input  logic              iorq,
   input  logic              rd,
   input  logic              wr,
   input  logic [7:0]        A,
   input  logic              A14,
   input  logic              A15,
   input  logic [7:0]        D,
   output logic              lsoe,
   output logic              moe,
   output logic              mwe,
   output logic              mce,
   output logic [PAGE_W-1:0] ma,
   output logic              romblk,
   output logic              wp
);

   logic iorq_s, rd_s, wr_s;

   z80_sync2 u_sync_iorq (.clk(clk), .rst_n(reset), .d(iorq), .q(iorq_s));
   z80_sync2 u_sync_rd   (.clk(clk), .rst_n(reset), .d(rd),   .q(rd_s));
   z80_sync2 u_sync_wr   (.clk(clk), .rst_n(reset), .d(wr),   .q(wr_s));

   logic       rdc, wrc;
   logic       rdc_q, wrc_q;
   logic [1:0] settle;
   logic       rd_ev, wr_ev;

   assign rdc = iorq_s | rd_s;
   assign wrc = iorq_s | wr_s;

   // Edge history only tracks real pin levels once the synchroniser has flushed its
   // reset value, so a strobe held low across reset release must rise before it counts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         settle <= 2'b00;
         rdc_q  <= 1'b0;
         wrc_q  <= 1'b0;
      end else begin
         settle <= {settle[0], 1'b1};
         rdc_q  <= settle[1] & rdc;
         wrc_q  <= settle[1] & wrc;
      end
   end

   assign rd_ev = rdc_q & ~rdc;
   assign wr_ev = wrc_q & ~wrc;

   state_e              state, state_nxt;
   logic [7:0]          a_q, a_nxt;
   logic [PAGE_W-1:0]   dpg_q, dpg_nxt;
   logic                dwp_q, dwp_nxt;
   logic                is_wr_q, is_wr_nxt;
   logic                en_q, en_nxt;
   logic [PAGE_W-1:0]   page_q, page_nxt;
   logic                wp_q, wp_nxt;

   // State and control registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         a_q     <= 8'h00;
         dpg_q   <= '0;
         dwp_q   <= 1'b0;
         is_wr_q <= 1'b0;
         en_q    <= 1'b0;
         page_q  <= '0;
         wp_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         a_q     <= a_nxt;
         dpg_q   <= dpg_nxt;
         dwp_q   <= dwp_nxt;
         is_wr_q <= is_wr_nxt;
         en_q    <= en_nxt;
         page_q  <= page_nxt;
         wp_q    <= wp_nxt;
      end
   end

   // Next-state and register updates for the port-decode FSM.
   always_comb begin
      state_nxt = state;
      a_nxt     = a_q;
      dpg_nxt   = dpg_q;
      dwp_nxt   = dwp_q;
      is_wr_nxt = is_wr_q;
      en_nxt    = en_q;
      page_nxt  = page_q;
      wp_nxt    = wp_q;
      unique case (state)
         IDLE: begin
            // Another bus master owns the bus while bsrq is low.
            if (bsrq && (rd_ev || wr_ev)) begin
               state_nxt = DECODE;
               a_nxt     = A;
               dpg_nxt   = D[PAGE_W-1:0];
               dwp_nxt   = D[7];
               is_wr_nxt = ~rd_ev;
            end
         end
         DECODE: begin
            state_nxt = HOLD;
            if (!is_wr_q && a_q == PORT_ON) begin
               en_nxt = 1'b1;
            end else if (!is_wr_q && a_q == PORT_OFF) begin
               en_nxt = 1'b0;
            end else if (is_wr_q && a_q == PORT_PAGE) begin
               page_nxt = dpg_q;
               wp_nxt   = dwp_q;
            end
         end
         HOLD: begin
            if (iorq_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   logic win;

   // SRAM strobes follow the live bus so memory timing is not delayed by clk.
   assign win    = en_q & ~A15 & ~A14;
   assign lsoe   = ~bsrq;
   assign mce    = ~bsrq | ~win | mreq;
   assign moe    = mce | rd;
   assign mwe    = mce | wr | wp_q;
   assign ma     = page_q;
   assign romblk = en_q;
   assign wp     = wp_q;

endmodule
